// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Purpose  : Multi-cycle sequencer for an external 8-bit ALU plus a 4-entry
//            operand register file. It accepts one reg-to-reg operation at a
//            time and steps it through READ -> EXEC1 -> [EXEC2] -> WB.
//            ADC is built from two ADD passes because the ALU has no carry-in.
// Ports    : clk_i, rst_ni            clock, synchronous active-low reset
//            op_valid_i/op_ready_o    operation handshake
//            op_code_i/op_rd_i/op_ra_i/op_rb_i  operation fields
//            wr_en_i/wr_addr_i/wr_data_i        host register-file write
//            rd_addr_i/rd_data_o      combinational debug read
//            alu_a_o/alu_b_o/alu_fs_o/alu_c_i/alu_flag_i  external ALU link
//            done_o, result_o, flags_o  completion pulse, last result, flags
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
  parameter int NREG = 4,
  parameter int DW   = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          op_valid_i,
  output logic          op_ready_o,
  input  logic [1:0]    op_code_i,
  input  logic [1:0]    op_rd_i,
  input  logic [1:0]    op_ra_i,
  input  logic [1:0]    op_rb_i,
  input  logic          wr_en_i,
  input  logic [1:0]    wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [1:0]    rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  output logic [1:0]    alu_fs_o,
  input  logic [DW-1:0] alu_c_i,
  input  logic [3:0]    alu_flag_i,
  output logic          done_o,
  output logic [DW-1:0] result_o,
  output logic [3:0]    flags_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_EXEC1 = 3'd2;
  localparam logic [2:0] ST_EXEC2 = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_ADC = 2'b11;
  localparam logic [1:0] FS_PARK = 2'b11;

  logic [2:0]    state_q, state_d;
  logic [1:0]    code_q, rd_q, ra_q, rb_q;
  logic [DW-1:0] opa_q, opb_q, tmp_q, result_q;
  logic          c_q, z_q, eq_q;
  logic [3:0]    flags_q;
  logic [DW-1:0] regs_q [NREG];
  logic          wb_we;

  // Register file writes commit only in WB and never for CMP.
  assign wb_we = (state_q == ST_WB) && (code_q != OP_CMP);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (op_valid_i) state_d = ST_READ;
      ST_READ:  state_d = ST_EXEC1;
      ST_EXEC1: state_d = (code_q == OP_ADC) ? ST_EXEC2 : ST_WB;
      ST_EXEC2: state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU drive: operands only during execute passes, otherwise parked.
  // --------------------------------------------------------------------------
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_fs_o = FS_PARK;
    if (state_q == ST_EXEC1) begin
      alu_a_o  = opa_q;
      alu_b_o  = opb_q;
      alu_fs_o = (code_q == OP_ADC) ? OP_ADD : code_q;
    end else if (state_q == ST_EXEC2) begin
      // Second ADC pass adds the architectural carry left by the previous op.
      alu_a_o  = tmp_q;
      alu_b_o  = {{(DW-1){1'b0}}, flags_q[0]};
      alu_fs_o = OP_ADD;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer state and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      tmp_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      eq_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (op_valid_i) begin
            code_q <= op_code_i;
            rd_q   <= op_rd_i;
            ra_q   <= op_ra_i;
            rb_q   <= op_rb_i;
          end
        end
        ST_READ: begin
          // Non-blocking read: a host write on this same edge is not seen.
          opa_q <= regs_q[ra_q];
          opb_q <= regs_q[rb_q];
        end
        ST_EXEC1: begin
          tmp_q <= alu_c_i;
          c_q   <= alu_flag_i[0];
          z_q   <= alu_flag_i[2];
          eq_q  <= alu_flag_i[3];
        end
        ST_EXEC2: begin
          // The two carries are mutually exclusive, so OR is the true carry.
          tmp_q <= alu_c_i;
          z_q   <= alu_flag_i[2];
          c_q   <= c_q | alu_flag_i[0];
        end
        ST_WB: begin
          if (code_q == OP_CMP) begin
            flags_q <= {eq_q, 3'b000};
          end else begin
            result_q <= tmp_q;
            flags_q  <= {1'b0, z_q, 1'b0, c_q};
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register file: writeback has priority over a host write to the same entry.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          regs_q[gi] <= '0;
        end else if (wb_we && (rd_q == 2'(gi))) begin
          regs_q[gi] <= tmp_q;
        end else if (wr_en_i && (wr_addr_i == 2'(gi))) begin
          regs_q[gi] <= wr_data_i;
        end
      end
    end
  endgenerate

  assign rd_data_o  = regs_q[rd_addr_i];
  assign op_ready_o = (state_q == ST_IDLE);
  assign done_o     = (state_q == ST_WB);
  assign result_o   = result_q;
  assign flags_o    = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Purpose  : Directed self-checking bench for alu_seq_ctrl with a behavioural
//            model of the external 8-bit ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       op_valid_i = 1'b0;
  logic       op_ready_o;
  logic [1:0] op_code_i = '0, op_rd_i = '0, op_ra_i = '0, op_rb_i = '0;
  logic       wr_en_i = 1'b0;
  logic [1:0] wr_addr_i = '0;
  logic [7:0] wr_data_i = '0;
  logic [1:0] rd_addr_i = '0;
  logic [7:0] rd_data_o, alu_a_o, alu_b_o, alu_c_i, result_o;
  logic [1:0] alu_fs_o;
  logic [3:0] alu_flag_i, flags_o;
  logic       done_o;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq_ctrl #(.NREG(4), .DW(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_code_i(op_code_i), .op_rd_i(op_rd_i), .op_ra_i(op_ra_i), .op_rb_i(op_rb_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_fs_o(alu_fs_o),
    .alu_c_i(alu_c_i), .alu_flag_i(alu_flag_i),
    .done_o(done_o), .result_o(result_o), .flags_o(flags_o)
  );

  always #5 clk_i = ~clk_i;

  // External ALU: flags {cmp-equal, zero, 0, carry/borrow}; parked when fs=11.
  always_comb begin
    logic [8:0] sum;
    sum        = {1'b0, alu_a_o} + {1'b0, alu_b_o};
    alu_c_i    = 8'h00;
    alu_flag_i = 4'h0;
    case (alu_fs_o)
      2'b00: begin
        alu_c_i    = sum[7:0];
        alu_flag_i = {1'b0, (sum[7:0] == 8'h00), 1'b0, sum[8]};
      end
      2'b01: begin
        alu_c_i    = alu_a_o - alu_b_o;
        alu_flag_i = {1'b0, (alu_a_o == alu_b_o), 1'b0, (alu_a_o < alu_b_o)};
      end
      2'b10: begin
        alu_c_i    = alu_a_o - alu_b_o;
        alu_flag_i = {(alu_a_o == alu_b_o), (alu_a_o == alu_b_o), 1'b0, (alu_a_o < alu_b_o)};
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rd_addr_i = a;
    #1;
    chk(tag, rd_data_o, exp);
  endtask

  // Issue one op, measure cycles from the accept edge to done, step past WB.
  task automatic run_op(input string tag, input logic [1:0] code, input logic [1:0] rd,
                        input logic [1:0] ra, input logic [1:0] rb, input int exp_lat);
    int lat;
    op_valid_i = 1'b1; op_code_i = code; op_rd_i = rd; op_ra_i = ra; op_rb_i = rb;
    tick();
    op_valid_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    tick();
    chk({tag, "_ready"}, op_ready_o, 1'b1);
  endtask

  initial begin
    // Reset state
    rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    chk("rst_ready", op_ready_o, 1'b1);
    chk("rst_done", done_o, 1'b0);
    chk("rst_result", result_o, 8'h00);
    chk("rst_flags", flags_o, 4'h0);
    chk("rst_fs_park", alu_fs_o, 2'b11);
    for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), 8'h00);

    // ADD 5+3
    host_wr(2'd0, 8'h05);
    host_wr(2'd1, 8'h03);
    run_op("add1", 2'b00, 2'd2, 2'd0, 2'd1, 3);
    chk_reg("add1_r2", 2'd2, 8'h08);
    chk("add1_result", result_o, 8'h08);
    chk("add1_flags", flags_o, 4'b0000);

    // ADD FF+01 then ADC FF+FF+carry
    host_wr(2'd0, 8'hFF);
    host_wr(2'd1, 8'h01);
    run_op("add2", 2'b00, 2'd3, 2'd0, 2'd1, 3);
    chk_reg("add2_r3", 2'd3, 8'h00);
    chk("add2_flags", flags_o, 4'b0101);
    run_op("adc", 2'b11, 2'd3, 2'd0, 2'd0, 4);
    chk_reg("adc_r3", 2'd3, 8'hFF);
    chk("adc_result", result_o, 8'hFF);
    chk("adc_flags", flags_o, 4'b0001);

    // SUB with borrow, then SUB to zero
    host_wr(2'd0, 8'h05);
    host_wr(2'd1, 8'h03);
    run_op("sub1", 2'b01, 2'd2, 2'd1, 2'd0, 3);
    chk_reg("sub1_r2", 2'd2, 8'hFE);
    chk("sub1_flags", flags_o, 4'b0001);
    run_op("sub2", 2'b01, 2'd2, 2'd0, 2'd0, 3);
    chk_reg("sub2_r2", 2'd2, 8'h00);
    chk("sub2_result", result_o, 8'h00);
    chk("sub2_flags", flags_o, 4'b0100);

    // CMP equal operands (r0=05, r3=05): fs=10 only in EXEC1
    host_wr(2'd3, 8'h05);
    op_valid_i = 1'b1; op_code_i = 2'b10; op_rd_i = 2'd1; op_ra_i = 2'd0; op_rb_i = 2'd3;
    tick();
    op_valid_i = 1'b0;
    chk("cmp_read_fs", alu_fs_o, 2'b11);
    chk("cmp_read_ready", op_ready_o, 1'b0);
    tick();
    chk("cmp_exec_fs", alu_fs_o, 2'b10);
    chk("cmp_exec_a", alu_a_o, 8'h05);
    chk("cmp_exec_b", alu_b_o, 8'h05);
    tick();
    chk("cmp_wb_done", done_o, 1'b1);
    chk("cmp_wb_fs", alu_fs_o, 2'b11);
    tick();
    chk("cmp_flags", flags_o, 4'b1000);
    chk("cmp_result", result_o, 8'h00);
    chk_reg("cmp_r1", 2'd1, 8'h03);

    // Reset during EXEC1 of an ADD
    op_valid_i = 1'b1; op_code_i = 2'b00; op_rd_i = 2'd1; op_ra_i = 2'd0; op_rb_i = 2'd3;
    tick();
    op_valid_i = 1'b0;
    tick();
    chk("abort_exec_fs", alu_fs_o, 2'b00);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("abort_ready", op_ready_o, 1'b1);
    chk("abort_done", done_o, 1'b0);
    chk("abort_flags", flags_o, 4'h0);
    chk_reg("abort_r1", 2'd1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", done_o, 1'b0);
    end

    // Host write to ra during READ, host write to rd during WB
    host_wr(2'd0, 8'h10);
    host_wr(2'd1, 8'h20);
    op_valid_i = 1'b1; op_code_i = 2'b00; op_rd_i = 2'd2; op_ra_i = 2'd0; op_rb_i = 2'd1;
    tick();
    op_valid_i = 1'b0;
    wr_en_i = 1'b1; wr_addr_i = 2'd0; wr_data_i = 8'h77;
    tick();
    wr_en_i = 1'b0;
    chk("race_exec_a", alu_a_o, 8'h10);
    chk("race_exec_b", alu_b_o, 8'h20);
    tick();
    chk("race_wb_done", done_o, 1'b1);
    wr_en_i = 1'b1; wr_addr_i = 2'd2; wr_data_i = 8'hAA;
    tick();
    wr_en_i = 1'b0;
    chk_reg("race_r2", 2'd2, 8'h30);
    chk_reg("race_r0", 2'd0, 8'h77);
    chk("race_result", result_o, 8'h30);
    chk("race_flags", flags_o, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
